// File: rtl/progmem_pkg.sv
// Shared definitions for the program-memory arbiter: default geometry,
// FSM state encoding and the master index type.
package progmem_pkg;

  localparam int          DEF_MEM_SIZE_BITS = 10;
  localparam logic [31:0] DEF_MEM_ADDR_MASK = 32'h0010_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef logic master_idx_t;

  localparam master_idx_t M0 = 1'b0;  // PicoRV32
  localparam master_idx_t M1 = 1'b1;  // QSPI boot loader

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to whichever master was not granted last.
module rr_arb2
  import progmem_pkg::*;
(
  input  logic [1:0]  i_req,
  input  master_idx_t i_last_grant,
  output logic        o_valid,
  output master_idx_t o_grant
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    o_valid = |i_req;
    o_grant = M0;
    case (i_req)
      2'b01:   o_grant = M0;
      2'b10:   o_grant = M1;
      2'b11:   o_grant = (i_last_grant == M0) ? M1 : M0;
      default: o_grant = M0;
    endcase
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port program SRAM.
// One access per three cycles: IDLE (grant) -> ISSUE (SRAM samples) -> RESP (ready).
module progmem_arbiter
  import progmem_pkg::*;
#(
  parameter int          MEM_SIZE_BITS = DEF_MEM_SIZE_BITS,
  parameter logic [31:0] MEM_ADDR_MASK = DEF_MEM_ADDR_MASK
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     m0_valid,
  output logic                     m0_ready,
  input  logic [31:0]              m0_addr,
  input  logic [31:0]              m0_wdata,
  input  logic [3:0]               m0_wstrb,
  output logic [31:0]              m0_rdata,
  input  logic                     m1_valid,
  output logic                     m1_ready,
  input  logic [31:0]              m1_addr,
  input  logic [31:0]              m1_wdata,
  input  logic [3:0]               m1_wstrb,
  output logic [31:0]              m1_rdata,
  output logic                     mem_en,
  output logic [3:0]               mem_we,
  output logic [MEM_SIZE_BITS-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  logic [1:0]  w_req;
  logic        w_pick_valid;
  master_idx_t w_pick;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;

  state_e                   r_state;
  master_idx_t              r_grant;
  master_idx_t              r_last_grant;
  logic                     r_m0_ready;
  logic                     r_m1_ready;
  logic                     r_mem_en;
  logic [3:0]               r_mem_we;
  logic [MEM_SIZE_BITS-1:0] r_mem_addr;
  logic [31:0]              r_mem_wdata;

  // Out-of-window requests belong to another slave and are ignored entirely.
  assign w_req[0] = m0_valid && ((m0_addr & MEM_ADDR_MASK) != '0);
  assign w_req[1] = m1_valid && ((m1_addr & MEM_ADDR_MASK) != '0);

  rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_grant      (w_pick)
  );

  always_comb begin
    w_sel_addr  = m0_addr;
    w_sel_wdata = m0_wdata;
    w_sel_wstrb = m0_wstrb;
    if (w_pick == M1) begin
      w_sel_addr  = m1_addr;
      w_sel_wdata = m1_wdata;
      w_sel_wstrb = m1_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_grant      <= M0;
      r_last_grant <= M1;
      r_m0_ready   <= 1'b0;
      r_m1_ready   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_mem_en     <= 1'b1;
            r_mem_we     <= w_sel_wstrb;
            r_mem_addr   <= w_sel_addr[MEM_SIZE_BITS+1:2];
            r_mem_wdata  <= w_sel_wdata;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_en   <= 1'b0;
          r_mem_we   <= '0;
          r_m0_ready <= (r_grant == M0);
          r_m1_ready <= (r_grant == M1);
          r_state    <= RESP;
        end
        RESP: begin
          // The following IDLE cycle gives the master time to drop valid.
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_ready  = r_m0_ready;
  assign m1_ready  = r_m1_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign m0_rdata  = (r_grant == M0) ? mem_rdata : '0;
  assign m1_rdata  = (r_grant == M1) ? mem_rdata : '0;

endmodule
